entrada_dados: RTL and testbench

- Input-side counterpart of the processor's display/output path.
- Captures a signed decimal number entered by the user on switches as packed BCD digits plus a sign switch.
- Converts it iteratively (reverse double-dabble, one bit per cycle) into a 32-bit two's-complement word and presents it to the processor datapath during an IN instruction.
- Handshake: the processor raises `in` and holds it until `pronto`.

---
 rtl/entrada_dados.sv | 152 +++++++++++++++
 tb/tb_entrada_dados.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/entrada_dados.sv
// entrada_dados: captures a signed BCD number from switches and converts it
// to a 32-bit two's-complement word for the processor's IN instruction.
// The conversion is a reverse double-dabble that produces one bit per cycle.
// Optional: define ENTRADA_DEBOUNCE_EN to filter `confirma` through a
// debouncer that needs DEBOUNCE stable-high cycles.

// Per-digit slice: validates the switch nibble and applies the
// reverse double-dabble correction to the shifted nibble.
module entrada_dados_digito (
   input  logic [3:0] chave,
   input  logic [3:0] desl,
   output logic [3:0] corr,
   output logic       valido
);
   assign valido = (chave <= 4'd9);
   assign corr   = (desl >= 4'd8) ? (desl - 4'd3) : desl;
endmodule

module entrada_dados #(
   parameter int DIGITOS  = 8,
   parameter int DEBOUNCE = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [4*DIGITOS-1:0]   bcd,
   input  logic                   neg,
   input  logic                   confirma,
   input  logic                   in,
   output logic [31:0]            entrada,
   output logic                   pronto,
   output logic                   ocupado,
   output logic                   erro
);
   localparam int W  = 4*DIGITOS;
   localparam int CW = $clog2(W) + 1;

   typedef enum logic [2:0] {OCIOSO, AGUARDA, CONVERTE, SINAL, PRONTO} estado_t;

   estado_t            estado, proximo;
   logic [W-1:0]       bcd_reg, bin_reg, bcd_desl, bcd_corr;
   logic [2*W-1:0]     conc;
   logic [DIGITOS-1:0] dig_ok;
   logic [CW-1:0]      passo;
   logic [31:0]        mag;
   logic               neg_reg, conf_f, conf_prev, evento;
   logic               carrega, invalido;

`ifdef ENTRADA_DEBOUNCE_EN
   localparam int DW = $clog2(DEBOUNCE + 1);
   logic [DW-1:0] deb_cnt;

   // Count consecutive high cycles of the raw button, saturating at DEBOUNCE.
   always_ff @(posedge clock) begin
      if (reset)                          deb_cnt <= '0;
      else if (!confirma)                 deb_cnt <= '0;
      else if (deb_cnt != DW'(DEBOUNCE))  deb_cnt <= deb_cnt + DW'(1);
   end

   // Filtered level drops at once when the raw input goes low.
   assign conf_f = confirma && (deb_cnt == DW'(DEBOUNCE));
`else
   assign conf_f = confirma;
`endif

   assign evento = conf_f & ~conf_prev;

   // One shift step: {bcd,bin} >> 1, then each shifted digit >= 8 loses 3.
   assign conc     = {bcd_reg, bin_reg} >> 1;
   assign bcd_desl = conc[2*W-1:W];
   assign mag      = 32'(bin_reg);

   for (genvar i = 0; i < DIGITOS; i++) begin : g_dig
      entrada_dados_digito u_dig (
         .chave  (bcd[4*i +: 4]),
         .desl   (bcd_desl[4*i +: 4]),
         .corr   (bcd_corr[4*i +: 4]),
         .valido (dig_ok[i])
      );
   end

   assign ocupado = (estado == CONVERTE);
   assign pronto  = (estado == PRONTO);

   // State register.
   always_ff @(posedge clock) begin
      if (reset) estado <= OCIOSO;
      else       estado <= proximo;
   end

   // Next-state and load/error strobes; dropping `in` always aborts.
   always_comb begin
      proximo  = estado;
      carrega  = 1'b0;
      invalido = 1'b0;
      case (estado)
         OCIOSO:   if (in) proximo = AGUARDA;
         AGUARDA: begin
            if (!in) proximo = OCIOSO;
            else if (evento) begin
               if (&dig_ok) begin
                  carrega = 1'b1;
                  proximo = CONVERTE;
               end else begin
                  invalido = 1'b1;
               end
            end
         end
         CONVERTE: begin
            if (!in)                         proximo = OCIOSO;
            else if (passo == CW'(W - 1))    proximo = SINAL;
         end
         SINAL:    proximo = PRONTO;
         PRONTO:   if (!in) proximo = OCIOSO;
         default:  proximo = OCIOSO;
      endcase
   end

   // Edge-detect history for the (possibly filtered) confirm level.
   always_ff @(posedge clock) begin
      if (reset) conf_prev <= 1'b0;
      else       conf_prev <= conf_f;
   end

   // Datapath: capture, shift-convert, then apply the sign once.
   always_ff @(posedge clock) begin
      if (reset) begin
         bcd_reg <= '0;
         bin_reg <= '0;
         neg_reg <= 1'b0;
         passo   <= '0;
         entrada <= '0;
         erro    <= 1'b0;
      end else begin
         if (carrega) begin
            bcd_reg <= bcd;
            bin_reg <= '0;
            neg_reg <= neg;
            passo   <= '0;
            erro    <= 1'b0;
         end else if (invalido) begin
            erro    <= 1'b1;
         end
         if (estado == CONVERTE) begin
            bcd_reg <= bcd_corr;
            bin_reg <= conc[W-1:0];
            passo   <= passo + CW'(1);
         end
         if (estado == SINAL)
            entrada <= neg_reg ? (~mag + 32'd1) : mag;
      end
   end
endmodule

// File: tb/tb_entrada_dados.sv
// Self-checking bench for entrada_dados: directed cases plus randomized BCD
// captures compared against a decimal-arithmetic reference model.
module tb_entrada_dados;
   localparam int DIGITOS  = 8;
   localparam int DEBOUNCE = 16;
   localparam int W        = 4*DIGITOS;
`ifdef ENTRADA_DEBOUNCE_EN
   localparam int PRESS  = DEBOUNCE + 4;
   localparam int ATRASO = DEBOUNCE;
`else
   localparam int PRESS  = 1;
   localparam int ATRASO = 0;
`endif

   logic          clock = 1'b0;
   logic          reset, neg, confirma, in;
   logic [W-1:0]  bcd;
   logic [31:0]   entrada;
   logic          pronto, ocupado, erro;
   int            n_chk = 0, n_err = 0;

   always #5 clock = ~clock;

   entrada_dados #(.DIGITOS(DIGITOS), .DEBOUNCE(DEBOUNCE)) dut (
      .clock    (clock),
      .reset    (reset),
      .bcd      (bcd),
      .neg      (neg),
      .confirma (confirma),
      .in       (in),
      .entrada  (entrada),
      .pronto   (pronto),
      .ocupado  (ocupado),
      .erro     (erro)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reference: decimal value of the digits, negated in 32-bit arithmetic.
   function automatic logic [31:0] modelo(input logic [W-1:0] v, input logic s);
      longint m = 0;
      for (int i = DIGITOS - 1; i >= 0; i--) m = m*10 + longint'(v[4*i +: 4]);
      if (s) m = -m;
      return m[31:0];
   endfunction

   // Valid capture from AGUARDA; switches scrambled once conversion starts.
   task automatic converte(input logic [W-1:0] v, input logic s, input logic [31:0] esp);
      int ciclos = 0, ocup = 0;
      bcd = v; neg = s; confirma = 1'b1;
      while (!pronto && ciclos < 200) begin
         tick();
         ciclos++;
         if (ciclos == PRESS) confirma = 1'b0;
         if (ocupado) begin
            ocup++;
            bcd = W'($urandom);
            neg = 1'($urandom);
         end
      end
      confirma = 1'b0;
      chk("latencia", 32'(ciclos), 32'(W + 2 + ATRASO));
      chk("ocupado_ciclos", 32'(ocup), 32'(W));
      chk("entrada", entrada, esp);
      chk("erro_limpo", 32'(erro), 32'd0);
   endtask

   // PRONTO holds while in=1; dropping in clears pronto next cycle.
   task automatic libera(input logic [31:0] esp);
      tick(); tick(); tick();
      chk("pronto_mantido", 32'(pronto), 32'd1);
      chk("entrada_mantida", entrada, esp);
      in = 1'b0;
      tick();
      chk("pronto_baixa", 32'(pronto), 32'd0);
      chk("entrada_apos", entrada, esp);
      in = 1'b1;
      tick();
   endtask

   task automatic invalido(input logic [W-1:0] v);
      int ocup = 0;
      bcd = v; neg = 1'($urandom); confirma = 1'b1;
      for (int c = 1; c <= PRESS + ATRASO + 5; c++) begin
         tick();
         if (c == PRESS) confirma = 1'b0;
         if (ocupado) ocup++;
      end
      confirma = 1'b0;
      chk("erro_set", 32'(erro), 32'd1);
      chk("pronto_inval", 32'(pronto), 32'd0);
      chk("sem_conversao", 32'(ocup), 32'd0);
   endtask

   // Starts a conversion and returns once `extra` cycles into CONVERTE.
   task automatic inicia(input logic [W-1:0] v, input int extra);
      int c = 0;
      bcd = v; neg = 1'b0; confirma = 1'b1;
      while (!ocupado && c < 100) begin
         tick();
         c++;
         if (c == PRESS) confirma = 1'b0;
      end
      confirma = 1'b0;
      chk("inicio", 32'(ocupado), 32'd1);
      for (int i = 1; i < extra; i++) tick();
   endtask

   initial begin
      logic [W-1:0] v;
      logic [31:0]  ant;
      int           k, subidas_o, subidas_p;
      logic         o_ant, p_ant;

      reset = 1'b1; in = 1'b0; confirma = 1'b0; bcd = '0; neg = 1'b0;
      tick(); tick();
      chk("rst_entrada", entrada, 32'd0);
      chk("rst_pronto", 32'(pronto), 32'd0);
      chk("rst_ocupado", 32'(ocupado), 32'd0);
      chk("rst_erro", 32'(erro), 32'd0);
      reset = 1'b0; in = 1'b1;
      tick();

      converte(32'h00001234, 1'b0, 32'h000004D2); libera(32'h000004D2);
      converte(32'h00000001, 1'b1, 32'hFFFFFFFF); libera(32'hFFFFFFFF);
      converte(32'h00000000, 1'b1, 32'h00000000); libera(32'h00000000);
      converte(32'h99999999, 1'b0, 32'h05F5E0FF); libera(32'h05F5E0FF);
      converte(32'h99999999, 1'b1, 32'hFA0A1F01); libera(32'hFA0A1F01);

      invalido(32'h0000A000);
      converte(32'h00000042, 1'b0, 32'h0000002A); libera(32'h0000002A);

      // Abort at cycle 10 of CONVERTE.
      ant = entrada;
      inicia(32'h00567890, 10);
      in = 1'b0;
      k = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (pronto || ocupado) k++;
      end
      chk("abort_sem_pronto", 32'(k), 32'd0);
      chk("abort_entrada", entrada, ant);
      in = 1'b1;
      tick();

      // Confirm held high: one conversion even across a handshake cycle.
      bcd = 32'h00000777; neg = 1'b0; confirma = 1'b1;
      subidas_o = 0; subidas_p = 0; o_ant = 1'b0; p_ant = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (ocupado && !o_ant) subidas_o++;
         if (pronto && !p_ant) begin
            subidas_p++;
            chk("segurado_entrada", entrada, 32'd777);
            in = 1'b0;
         end else begin
            in = 1'b1;
         end
         o_ant = ocupado; p_ant = pronto;
      end
      confirma = 1'b0; in = 1'b1;
      tick(); tick();
      chk("segurado_conv", 32'(subidas_o), 32'd1);
      chk("segurado_pronto", 32'(subidas_p), 32'd1);

`ifdef ENTRADA_DEBOUNCE_EN
      // Short glitch must not pass the filter.
      bcd = 32'h00000005; confirma = 1'b1;
      k = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (i == 9) confirma = 1'b0;
         if (ocupado) k++;
      end
      chk("glitch", 32'(k), 32'd0);
`endif

      // Randomized captures, roughly a quarter with an invalid digit.
      for (int it = 0; it < 16; it++) begin
         for (int i = 0; i < DIGITOS; i++) v[4*i +: 4] = 4'($urandom_range(9, 0));
         if ($urandom_range(3, 0) == 0) begin
            k = $urandom_range(DIGITOS - 1, 0);
            v[4*k +: 4] = 4'($urandom_range(15, 10));
            invalido(v);
         end else begin
            ant = modelo(v, 1'($urandom));
            converte(v, ant[31], ant);
            libera(ant);
         end
      end

      // Reset mid-conversion clears every output.
      converte(32'h00003141, 1'b0, 32'h00000C45); libera(32'h00000C45);
      inicia(32'h00002718, 10);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_meio_entrada", entrada, 32'd0);
      chk("rst_meio_pronto", 32'(pronto), 32'd0);
      chk("rst_meio_ocupado", 32'(ocupado), 32'd0);
      chk("rst_meio_erro", 32'(erro), 32'd0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
